spi_master_bridge: RTL and testbench

- SPI Mode-0 master that produces the command/address/dummy/data byte protocol the SPI slave core decodes. It is the host end of that link.
- Takes single and burst read/write requests on a sys_clk command interface, serialises them onto SCLK/CS_N/MOSI and deserialises MISO into read words.
- Used as the protocol driver for SoC-to-SoC links and for loopback verification against the slave core.

---
 rtl/spi_master_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_spi_master_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_bridge
// Brief   : SPI mode-0 master driving the cmd/addr/dummy/data byte protocol.
// Revision: 1.0
// ============================================================================
module spi_master_bridge #(
  parameter int CLK_DIV     = 2,
  parameter int DUMMY_BYTES = 4,
  parameter int CS_GAP      = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [1:0]  cmd_size_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        spi_clk_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam logic [15:0] c_DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] c_GAP_LAST   = 16'(CS_GAP - 1);
  localparam logic [15:0] c_DUMMY_M1   = 16'((DUMMY_BYTES > 0) ? (8 * DUMMY_BYTES - 1) : 0);
  localparam bit          c_HAS_DUMMY  = (DUMMY_BYTES > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_CMD   = 2'd0,
    PH_ADDR  = 2'd1,
    PH_DUMMY = 2'd2,
    PH_DATA  = 2'd3
  } phase_t;

  state_t      r_state;
  phase_t      r_phase;
  logic [1:0]  r_op;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [8:0]  r_beats_left;
  logic [15:0] r_div;
  logic [15:0] r_gap;
  logic [15:0] r_fbits;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_stall;
  logic        r_sclk;
  logic        r_cs_n;
  logic        r_mosi;
  logic        r_busy;
  logic        r_done;
  logic        r_cmd_ready;
  logic        r_wr_ready;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;

  logic        w_is_read;
  logic        w_rd_phase;
  logic [15:0] w_data_bits_m1;
  logic [31:0] w_wr_word;
  logic        w_last_beat;
  logic        w_to_data;

  // op[0]==0 marks both single and burst reads
  assign w_is_read   = ~r_op[0];
  assign w_rd_phase  = (r_phase == PH_DATA) && w_is_read;
  assign w_last_beat = (r_beats_left == 9'd1);

  always_comb begin
    w_data_bits_m1 = 16'd31;
    w_wr_word      = wr_data_i;
    case (r_size)
      2'b00: begin
        w_data_bits_m1 = 16'd7;
        w_wr_word      = {wr_data_i[7:0], 24'd0};
      end
      2'b01: begin
        w_data_bits_m1 = 16'd15;
        w_wr_word      = {wr_data_i[15:0], 16'd0};
      end
      default: begin
        w_data_bits_m1 = 16'd31;
        w_wr_word      = wr_data_i;
      end
    endcase
  end

  always_comb begin
    w_to_data = 1'b0;
    case (r_phase)
      PH_ADDR:  w_to_data = !(w_is_read && c_HAS_DUMMY);
      PH_DUMMY: w_to_data = 1'b1;
      PH_DATA:  w_to_data = !w_last_beat;
      default:  w_to_data = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= PH_CMD;
      r_op         <= 2'b00;
      r_size       <= 2'b00;
      r_addr       <= 32'd0;
      r_beats_left <= 9'd0;
      r_div        <= 16'd0;
      r_gap        <= 16'd0;
      r_fbits      <= 16'd0;
      r_tx         <= 32'd0;
      r_rx         <= 32'd0;
      r_stall      <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_wr_ready   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= 32'd0;
    end else begin
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op         <= cmd_op_i;
            r_size       <= cmd_size_i;
            r_addr       <= cmd_addr_i;
            r_beats_left <= cmd_op_i[1] ? ({1'b0, cmd_len_i} + 9'd1) : 9'd1;
            r_phase      <= PH_CMD;
            r_fbits      <= 16'd7;
            r_mosi       <= cmd_op_i[1];
            r_tx         <= {cmd_op_i[0], cmd_size_i, 4'b0000, 25'd0};
            r_rx         <= 32'd0;
            r_stall      <= 1'b0;
            r_div        <= 16'd0;
            r_cs_n       <= 1'b0;
            r_busy       <= 1'b1;
            r_cmd_ready  <= 1'b0;
            r_state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_div == c_DIV_LAST) begin
            r_div   <= 16'd0;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end

        S_SHIFT: begin
          if (r_stall) begin
            // SCLK parked low until the host offers the next write beat
            if (wr_valid_i) begin
              r_stall    <= 1'b0;
              r_wr_ready <= 1'b1;
              r_mosi     <= w_wr_word[31];
              r_tx       <= {w_wr_word[30:0], 1'b0};
              r_div      <= 16'd0;
            end
          end else if (r_div != c_DIV_LAST) begin
            r_div <= r_div + 16'd1;
          end else begin
            r_div <= 16'd0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              if (w_rd_phase) begin
                if (r_fbits == 16'd0) begin
                  r_rd_data  <= {r_rx[30:0], spi_miso_i};
                  r_rd_valid <= 1'b1;
                  r_rx       <= 32'd0;
                end else begin
                  r_rx <= {r_rx[30:0], spi_miso_i};
                end
              end
            end else begin
              r_sclk <= 1'b0;
              if (r_fbits != 16'd0) begin
                r_fbits <= r_fbits - 16'd1;
                r_mosi  <= r_tx[31];
                r_tx    <= {r_tx[30:0], 1'b0};
              end else if (r_phase == PH_DATA && w_last_beat) begin
                r_mosi  <= 1'b0;
                r_state <= S_HOLD;
              end else if (w_to_data) begin
                if (r_phase == PH_DATA) begin
                  r_beats_left <= r_beats_left - 9'd1;
                end
                r_phase <= PH_DATA;
                r_fbits <= w_data_bits_m1;
                if (w_is_read) begin
                  r_mosi <= 1'b0;
                  r_tx   <= 32'd0;
                end else if (wr_valid_i) begin
                  r_wr_ready <= 1'b1;
                  r_mosi     <= w_wr_word[31];
                  r_tx       <= {w_wr_word[30:0], 1'b0};
                end else begin
                  r_stall <= 1'b1;
                end
              end else if (r_phase == PH_CMD) begin
                r_phase <= PH_ADDR;
                r_fbits <= 16'd31;
                r_mosi  <= r_addr[31];
                r_tx    <= {r_addr[30:0], 1'b0};
              end else begin
                r_phase <= PH_DUMMY;
                r_fbits <= c_DUMMY_M1;
                r_mosi  <= 1'b0;
                r_tx    <= 32'd0;
              end
            end
          end
        end

        S_HOLD: begin
          if (r_div == c_DIV_LAST) begin
            r_div   <= 16'd0;
            r_cs_n  <= 1'b1;
            r_gap   <= 16'd0;
            r_done  <= (c_GAP_LAST == 16'd0);
            r_state <= S_GAP;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end

        S_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_gap  <= r_gap + 16'd1;
            r_done <= ((r_gap + 16'd1) == c_GAP_LAST);
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cs_n      <= 1'b1;
          r_sclk      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign wr_ready_o  = r_wr_ready;
  assign rd_data_o   = r_rd_data;
  assign rd_valid_o  = r_rd_valid;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign spi_clk_o   = r_sclk;
  assign spi_cs_n_o  = r_cs_n;
  assign spi_mosi_o  = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_bridge
// Brief   : Directed bench for spi_master_bridge with a behavioural SPI slave.
// Revision: 1.0
// ============================================================================
module tb_spi_master_bridge;

  localparam int HDR_RD_BITS = 72;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_size = 2'b00;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int total = 0;
  int bad = 0;

  // slave / monitor state
  logic [7:0]  rd_bytes [8];
  logic [7:0]  cap [16];
  logic [31:0] rd_log [16];
  logic [7:0]  acc = 8'd0;
  int n_rise = 0, cap_n = 0, rd_cnt = 0, n_wrr = 0, n_done = 0, gap_run = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1;

  spi_master_bridge #(.CLK_DIV(2), .DUMMY_BYTES(4), .CS_GAP(10)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_size_i  (cmd_size),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .wr_data_i   (wr_data),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .busy_o      (busy),
    .done_o      (done),
    .spi_clk_o   (sclk),
    .spi_cs_n_o  (cs_n),
    .spi_mosi_o  (mosi),
    .spi_miso_i  (miso)
  );

  always #5 sys_clk = ~sys_clk;

  // Mode-0 slave: capture MOSI on SCLK rise, present next MISO bit after SCLK fall
  always @(negedge sys_clk) begin
    int idx;
    if (!cs_n && p_cs) begin
      n_rise = 0; cap_n = 0; acc = 8'd0; miso = 1'b0; gap_run = 0;
    end
    if (!cs_n && sclk && !p_sclk) begin
      acc = {acc[6:0], mosi};
      n_rise++;
      if (n_rise % 8 == 0 && cap_n < 16) begin
        cap[cap_n] = acc;
        cap_n++;
      end
    end
    if (!cs_n && !sclk && p_sclk) begin
      if (n_rise >= HDR_RD_BITS && n_rise < HDR_RD_BITS + 64) begin
        idx  = n_rise - HDR_RD_BITS;
        miso = rd_bytes[idx / 8][7 - (idx % 8)];
      end else begin
        miso = 1'b0;
      end
    end
    if (cs_n && busy) gap_run++;
    if (wr_ready) n_wrr++;
    if (done) n_done++;
    if (rd_valid && rd_cnt < 16) begin
      rd_log[rd_cnt] = rd_data;
      rd_cnt++;
    end
    p_sclk = sclk;
    p_cs   = cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] size,
                       input logic [31:0] addr, input logic [7:0] len);
    @(negedge sys_clk);
    cmd_op = op; cmd_size = size; cmd_addr = addr; cmd_len = len;
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, {31'd0, (k < 5000)}, 32'd1);
  endtask

  task automatic wait_wrr(input string tag);
    int k = 0;
    while (wr_ready !== 1'b1 && k < 2000) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, {31'd0, (k < 2000)}, 32'd1);
  endtask

  task automatic chk_bytes(input string tag, input logic [127:0] exp, input int n);
    chk({tag, "_nbytes"}, 32'(cap_n), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp[8*(n-1-i) +: 8]});
  endtask

  initial begin
    int wr0, dn0, rc0, k;
    logic stall_ok;
    for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h00;

    // reset
    repeat (5) @(negedge sys_clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // single word write
    wr0 = n_wrr; dn0 = n_done;
    wr_data = 32'hDEADBEEF; wr_valid = 1'b1;
    issue(2'b01, 2'b10, 32'h4, 8'd0);
    chk("sw_busy", {31'd0, busy}, 32'd1);
    chk("sw_cs_low", {31'd0, cs_n}, 32'd0);
    wait_wrr("sw_wrr_to");
    wr_valid = 1'b0;
    wait_idle("sw_idle_to");
    chk_bytes("sw", 128'h60_00000004_DEADBEEF, 9);
    chk("sw_rises", 32'(n_rise), 32'd72);
    chk("sw_wrr_cnt", 32'(n_wrr - wr0), 32'd1);
    chk("sw_done_cnt", 32'(n_done - dn0), 32'd1);
    chk("sw_gap", {31'd0, (gap_run >= 10)}, 32'd1);
    chk("sw_cs_idle", {31'd0, cs_n}, 32'd1);

    // single word read
    rc0 = rd_cnt;
    rd_bytes[0] = 8'hDE; rd_bytes[1] = 8'hAD; rd_bytes[2] = 8'hBE; rd_bytes[3] = 8'hEF;
    issue(2'b00, 2'b10, 32'h4, 8'd0);
    wait_idle("sr_idle_to");
    chk_bytes("sr", 128'h20_00000004_00000000_00000000, 13);
    chk("sr_rd_cnt", 32'(rd_cnt - rc0), 32'd1);
    chk("sr_rd_data", rd_log[rc0], 32'hDEADBEEF);

    // burst write with a stall before beat 2
    wr0 = n_wrr;
    wr_data = 32'h11223344; wr_valid = 1'b1;
    issue(2'b11, 2'b10, 32'h20, 8'd1);
    wait_wrr("bw_wrr0_to");
    wr_valid = 1'b0; wr_data = 32'h55667788;
    k = 0;
    while (n_rise < 72 && k < 2000) begin @(negedge sys_clk); k++; end
    chk("bw_reach_stall", {31'd0, (k < 2000)}, 32'd1);
    repeat (4) @(negedge sys_clk);
    stall_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (sclk !== 1'b0 || cs_n !== 1'b0 || n_rise != 72) stall_ok = 1'b0;
      @(negedge sys_clk);
    end
    chk("bw_stall_frozen", {31'd0, stall_ok}, 32'd1);
    wr_valid = 1'b1;
    wait_wrr("bw_wrr1_to");
    wr_valid = 1'b0;
    wait_idle("bw_idle_to");
    chk_bytes("bw", 128'hE0_00000020_11223344_55667788, 13);
    chk("bw_wrr_cnt", 32'(n_wrr - wr0), 32'd2);

    // burst read
    rc0 = rd_cnt;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    rd_bytes[4] = 8'h55; rd_bytes[5] = 8'h66; rd_bytes[6] = 8'h77; rd_bytes[7] = 8'h88;
    issue(2'b10, 2'b10, 32'h20, 8'd1);
    wait_idle("br_idle_to");
    chk("br_rd_cnt", 32'(rd_cnt - rc0), 32'd2);
    chk("br_rd0", rd_log[rc0], 32'h11223344);
    chk("br_rd1", rd_log[rc0 + 1], 32'h55667788);
    chk("br_first_byte", {24'd0, cap[0]}, 32'h000000A0);

    // byte read, zero-extended
    rc0 = rd_cnt;
    rd_bytes[0] = 8'hA5;
    issue(2'b00, 2'b00, 32'h8, 8'd0);
    wait_idle("br8_idle_to");
    chk_bytes("br8", 128'h00_00000008_00000000_00, 10);
    chk("br8_rd_cnt", 32'(rd_cnt - rc0), 32'd1);
    chk("br8_rd_data", rd_log[rc0], 32'h000000A5);

    // reset asserted mid-address aborts with no done pulse
    dn0 = n_done;
    wr_data = 32'hCAFEF00D; wr_valid = 1'b1;
    issue(2'b01, 2'b10, 32'h4, 8'd0);
    k = 0;
    while (n_rise < 12 && k < 1000) begin @(negedge sys_clk); k++; end
    chk("ra_reach_addr", {31'd0, (k < 1000)}, 32'd1);
    chk("ra_cs_low_before", {31'd0, cs_n}, 32'd0);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("ra_cs_async", {31'd0, cs_n}, 32'd1);
    chk("ra_sclk", {31'd0, sclk}, 32'd0);
    chk("ra_busy", {31'd0, busy}, 32'd0);
    wr_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (15) @(negedge sys_clk);
    chk("ra_no_done", 32'(n_done - dn0), 32'd0);
    chk("ra_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // next command completes normally
    dn0 = n_done;
    wr_data = 32'h12345678; wr_valid = 1'b1;
    issue(2'b01, 2'b10, 32'h8, 8'd0);
    wait_wrr("rn_wrr_to");
    wr_valid = 1'b0;
    wait_idle("rn_idle_to");
    chk_bytes("rn", 128'h60_00000008_12345678, 9);
    chk("rn_done_cnt", 32'(n_done - dn0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
